s_perm_check: RTL and testbench



---
 rtl/arc4_pkg.sv | 18 +
 rtl/s_read_pipe.sv | 46 ++++
 rtl/s_perm_check.sv | 163 ++++++++++++++++
 tb/tb_s_perm_check.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared constants and types for the ARC4 S-memory blocks.
// Depth/width constants for the 256x8 S array and the checker FSM state type.
// Imported by s_read_pipe and s_perm_check.
package arc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/s_read_pipe.sv
// Valid/index delay line that lines each issued S-memory address up with its rddata.
// Latency: READ_LAT cycles from in_vld/in_idx to tail_vld/tail_idx; busy = any stage valid.
// Ports: clk, rst (async active-high), in_vld/in_idx in; tail_vld/tail_idx/busy out. No backpressure.
module s_read_pipe
    import arc4_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_idx,
    output logic              tail_vld,
    output logic [ADDR_W-1:0] tail_idx,
    output logic              busy
);

    logic [READ_LAT-1:0]             vld_q, vld_d;
    logic [READ_LAT-1:0][ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        vld_d    = vld_q;
        idx_d    = idx_q;
        vld_d[0] = in_vld;
        idx_d[0] = in_idx;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign tail_vld = vld_q[READ_LAT-1];
    assign tail_idx = idx_q[READ_LAT-1];
    assign busy     = |vld_q;

endmodule

// File: rtl/s_perm_check.sv
// Read-only scanner of the 256x8 S memory: permutation / identity / duplicate checks.
// Ports: clk, rst (async active-high), en/rdy handshake, addr/rddata/wren memory port,
//        is_perm/is_ident/first_dup/dup_count results, out_valid/out_idx/out_data stream.
// Optional macro S_PERM_CHECK_STREAM_EN: drives the per-read stream; otherwise stream outputs are 0.
module s_perm_check
    import arc4_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] rddata,
    output logic              wren,
    output logic              is_perm,
    output logic              is_ident,
    output logic [ADDR_W-1:0] first_dup,
    output logic [CNT_W-1:0]  dup_count,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data
);

    state_t              state_q, state_d;
    logic                rdy_q, rdy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [S_DEPTH-1:0]  seen_q, seen_d;
    // Running scan state; only copied to the published outputs in DONE.
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0]   run_first_q, run_first_d;
    logic                run_ident_q, run_ident_d;
    logic                is_perm_q, is_perm_d;
    logic                is_ident_q, is_ident_d;
    logic [ADDR_W-1:0]   first_dup_q, first_dup_d;
    logic [CNT_W-1:0]    dup_count_q, dup_count_d;

    logic                tail_vld;
    logic [ADDR_W-1:0]   tail_idx;
    logic                pipe_busy;

    s_read_pipe #(.READ_LAT(READ_LAT)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (state_q == ISSUE),
        .in_idx   (addr_q),
        .tail_vld (tail_vld),
        .tail_idx (tail_idx),
        .busy     (pipe_busy)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        seen_d      = seen_q;
        run_cnt_d   = run_cnt_q;
        run_first_d = run_first_q;
        run_ident_d = run_ident_q;
        is_perm_d   = is_perm_q;
        is_ident_d  = is_ident_q;
        first_dup_d = first_dup_q;
        dup_count_d = dup_count_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    seen_d      = '0;
                    run_cnt_d   = '0;
                    run_first_d = '0;
                    run_ident_d = 1'b1;
                    addr_d      = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Last address is held rather than wrapped so the memory sees no stray read of 0.
                if (addr_q == ADDR_W'(S_DEPTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!pipe_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                is_perm_d   = (run_cnt_q == '0);
                is_ident_d  = run_ident_q;
                first_dup_d = run_first_q;
                dup_count_d = run_cnt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The pipe tail is never valid in IDLE, so this cannot collide with the start-of-scan clear.
        if (tail_vld) begin
            if (seen_q[rddata]) begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == '0) begin
                    run_first_d = tail_idx;
                end
            end
            seen_d[rddata] = 1'b1;
            if (rddata != tail_idx) begin
                run_ident_d = 1'b0;
            end
        end

        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b1;
            addr_q      <= '0;
            seen_q      <= '0;
            run_cnt_q   <= '0;
            run_first_q <= '0;
            run_ident_q <= 1'b0;
            is_perm_q   <= 1'b0;
            is_ident_q  <= 1'b0;
            first_dup_q <= '0;
            dup_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= rdy_d;
            addr_q      <= addr_d;
            seen_q      <= seen_d;
            run_cnt_q   <= run_cnt_d;
            run_first_q <= run_first_d;
            run_ident_q <= run_ident_d;
            is_perm_q   <= is_perm_d;
            is_ident_q  <= is_ident_d;
            first_dup_q <= first_dup_d;
            dup_count_q <= dup_count_d;
        end
    end

    assign rdy       = rdy_q;
    assign addr      = addr_q;
    assign wren      = 1'b0;
    assign is_perm   = is_perm_q;
    assign is_ident  = is_ident_q;
    assign first_dup = first_dup_q;
    assign dup_count = dup_count_q;

`ifdef S_PERM_CHECK_STREAM_EN
    // Stream mirrors the check stage; gated so idle cycles show zeros rather than raw rddata.
    assign out_valid = tail_vld;
    assign out_idx   = tail_vld ? tail_idx : '0;
    assign out_data  = tail_vld ? rddata   : '0;
`else
    assign out_valid = 1'b0;
    assign out_idx   = '0;
    assign out_data  = '0;
`endif

endmodule

// File: tb/tb_s_perm_check.sv
module tb_s_perm_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] addr;
    logic [7:0] rddata;
    logic       wren;
    logic       is_perm;
    logic       is_ident;
    logic [7:0] first_dup;
    logic [8:0] dup_count;
    logic       out_valid;
    logic [7:0] out_idx;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    s_perm_check #(.READ_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .addr      (addr),
        .rddata    (rddata),
        .wren      (wren),
        .is_perm   (is_perm),
        .is_ident  (is_ident),
        .first_dup (first_dup),
        .dup_count (dup_count),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    // S memory model with one cycle of read latency.
    logic [7:0] s_mem [256];
    always @(posedge clk) rddata <= s_mem[addr];

`ifdef S_PERM_CHECK_STREAM_EN
    localparam int EXP_STROBES = 256;
`else
    localparam int EXP_STROBES = 0;
`endif
    localparam int EXP_LAT = 259;

    typedef struct {
        logic       perm;
        logic       ident;
        logic [7:0] fd;
        logic [8:0] cnt;
    } res_t;

    res_t exp_q[$];
    res_t pub;

    int checks   = 0;
    int failures = 0;
    int strm_cnt = 0;
    int strm_err = 0;
    bit wren_hi  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model_scan();
        res_t r;
        bit   seen [256];
        r.cnt   = '0;
        r.fd    = '0;
        r.ident = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (seen[s_mem[i]]) begin
                if (r.cnt == 0) r.fd = 8'(i);
                r.cnt = r.cnt + 1'b1;
            end
            seen[s_mem[i]] = 1'b1;
            if (s_mem[i] != 8'(i)) r.ident = 1'b0;
        end
        r.perm = (r.cnt == 0);
        return r;
    endfunction

    always @(negedge clk) begin
        if (wren !== 1'b0) wren_hi = 1'b1;
        if (out_valid !== 1'b0) begin
            if (out_idx !== strm_cnt[7:0] || out_data !== s_mem[out_idx]) strm_err++;
            strm_cnt++;
        end
    end

    // Called at a falling edge with the DUT idle; returns at the falling edge where rdy is back.
    task automatic run_scan(input string tag, input bit hold);
        res_t r;
        int   n;
        exp_q.push_back(model_scan());
        strm_cnt = 0;
        strm_err = 0;
        en = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) en = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 128)
                check_eq({tag, " held_results"}, {is_perm, is_ident, first_dup, dup_count},
                         {pub.perm, pub.ident, pub.fd, pub.cnt});
        end while (!rdy && n < 400);
        check_eq({tag, " latency"}, n, EXP_LAT);
        r = exp_q.pop_front();
        check_eq({tag, " is_perm"},   is_perm,   r.perm);
        check_eq({tag, " is_ident"},  is_ident,  r.ident);
        check_eq({tag, " first_dup"}, first_dup, r.fd);
        check_eq({tag, " dup_count"}, dup_count, r.cnt);
        check_eq({tag, " strobes"},   strm_cnt,  EXP_STROBES);
        check_eq({tag, " strm_err"},  strm_err,  0);
        pub = r;
    endtask

    task automatic fill_ident();
        for (int i = 0; i < 256; i++) s_mem[i] = 8'(i);
    endtask

    initial begin
        int n;
        logic [7:0] t;
        int j;
        rst = 1'b1;
        en  = 1'b0;
        pub = '{1'b0, 1'b0, 8'd0, 9'd0};
        fill_ident();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst rdy",       rdy,       1);
        check_eq("rst addr",      addr,      0);
        check_eq("rst results",   {is_perm, is_ident, first_dup, dup_count}, 0);
        check_eq("rst stream",    {out_valid, out_idx, out_data}, 0);
        rst = 1'b0;
        @(negedge clk);

        fill_ident();
        run_scan("ident", 1'b0);

        fill_ident();
        s_mem[3] = 8'd7;
        s_mem[7] = 8'd3;
        run_scan("swap37", 1'b0);

        fill_ident();
        s_mem[20] = 8'd10;
        run_scan("dup20", 1'b0);

        for (int i = 0; i < 256; i++) s_mem[i] = 8'd0;
        run_scan("zeros", 1'b0);

        // Reset in the middle of an identity scan.
        fill_ident();
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        n = 0;
        while (addr !== 8'd100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst reach_addr", addr, 100);
        rst = 1'b1;
        #1;
        check_eq("midrst rdy",     rdy,  1);
        check_eq("midrst addr",    addr, 0);
        check_eq("midrst results", {is_perm, is_ident, first_dup, dup_count}, 0);
        check_eq("midrst stream",  {out_valid, out_idx, out_data}, 0);
        pub = '{1'b0, 1'b0, 8'd0, 9'd0};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_scan("post_rst_ident", 1'b0);

        // en held high across back-to-back scans with varied contents.
        fill_ident();
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = s_mem[i];
            s_mem[i] = s_mem[j];
            s_mem[j] = t;
        end
        run_scan("hold_perm", 1'b1);
        for (int i = 0; i < 256; i++) s_mem[i] = 8'($urandom_range(255, 0));
        run_scan("hold_rand", 1'b1);
        fill_ident();
        run_scan("hold_ident", 1'b1);
        en = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("wren_never_high", wren_hi, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
